pulse_timebase: RTL and testbench

- Parametrised, run-time programmable tick generator; successor to the fixed 1 ms pulse divider.
- Divides clk by a programmable period and emits one-cycle ticks. Also emits a slower cascaded tick every SUB_RATIO fast ticks (e.g. ms -> s).
- Supports continuous and one-shot modes, restart and stop.
- Feeds stopwatch, debounce and display-refresh logic on the 50 MHz board clock.

---
 rtl/pulse_timebase.sv | 124 ++++++++++++
 tb/tb_pulse_timebase.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/pulse_timebase.sv
// Programmable tick generator: divides clk by a run-time period, with a cascaded slow tick
// every SUB_RATIO ticks. Define PULSE_TIMEBASE_TICK_COUNT_EN to add a 32-bit tick_count output.
module pulse_timebase #(
  parameter int DIV_WIDTH   = 16,
  parameter int DEFAULT_DIV = 50000,
  parameter int SUB_RATIO   = 1000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 oneshot,
  input  logic [DIV_WIDTH-1:0] div_in,
  output logic                 tick,
  output logic                 tick_slow,
  output logic                 busy,
  output logic                 done
`ifdef PULSE_TIMEBASE_TICK_COUNT_EN
  ,
  output logic [31:0]          tick_count
`endif
);

  localparam int SLOW_W = $clog2(SUB_RATIO) + 1;
  localparam logic [DIV_WIDTH-1:0] DEFAULT_PERIOD = DIV_WIDTH'(DEFAULT_DIV);
  localparam logic [SLOW_W-1:0]    SLOW_LAST      = SLOW_W'(SUB_RATIO - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t               state;
  logic [DIV_WIDTH-1:0] prescaler;
  logic [DIV_WIDTH-1:0] period;
  logic [SLOW_W-1:0]    slow_cnt;
  logic                 oneshot_q;

  // period is never 0 while running, so period-1 cannot underflow.
  logic tick_due;
  assign tick_due = (state == RUN) && (prescaler == period - DIV_WIDTH'(1));

  // NOTE: all state below uses non-blocking assignments so every register samples
  // the pre-edge values of the others, regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      prescaler <= '0;
      period    <= '0;
      slow_cnt  <= '0;
      oneshot_q <= 1'b0;
      tick      <= 1'b0;
      tick_slow <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else if (stop) begin
      state     <= IDLE;
      prescaler <= '0;
      slow_cnt  <= '0;
      tick      <= 1'b0;
      tick_slow <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else if (start) begin
      // A start while running is a restart; holding start keeps the timebase at phase 0.
      state     <= RUN;
      period    <= (div_in == '0) ? DEFAULT_PERIOD : div_in;
      oneshot_q <= oneshot;
      prescaler <= '0;
      slow_cnt  <= '0;
      tick      <= 1'b0;
      tick_slow <= 1'b0;
      busy      <= 1'b1;
      done      <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (tick_due) begin
            prescaler <= '0;
            tick      <= 1'b1;
            if (slow_cnt == SLOW_LAST) begin
              slow_cnt  <= '0;
              tick_slow <= 1'b1;
            end else begin
              slow_cnt  <= slow_cnt + SLOW_W'(1);
              tick_slow <= 1'b0;
            end
            // One-shot retires on its first tick; done coincides with that tick.
            if (oneshot_q) begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              done  <= 1'b0;
            end
          end else begin
            prescaler <= prescaler + DIV_WIDTH'(1);
            tick      <= 1'b0;
            tick_slow <= 1'b0;
            done      <= 1'b0;
          end
        end
        default: begin
          prescaler <= '0;
          tick      <= 1'b0;
          tick_slow <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

`ifdef PULSE_TIMEBASE_TICK_COUNT_EN
  // Cleared by an accepted start, kept through stop so software can read the final count.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_count <= '0;
    end else if (!stop && start) begin
      tick_count <= '0;
    end else if (!stop && tick_due) begin
      tick_count <= tick_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pulse_timebase.sv
// Self-checking bench for pulse_timebase: directed steps plus random start/stop/reset traffic,
// compared every cycle against an arithmetic model of when ticks fall relative to the start edge.
module tb_pulse_timebase;

  localparam int DIV_WIDTH   = 16;
  localparam int DEFAULT_DIV = 500;
  localparam int SUB_RATIO   = 4;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 start = 1'b0;
  logic                 stop = 1'b0;
  logic                 oneshot = 1'b0;
  logic [DIV_WIDTH-1:0] div_in = '0;
  logic                 tick, tick_slow, busy, done;
`ifdef PULSE_TIMEBASE_TICK_COUNT_EN
  logic [31:0]          tick_count;
`endif

  pulse_timebase #(
    .DIV_WIDTH  (DIV_WIDTH),
    .DEFAULT_DIV(DEFAULT_DIV),
    .SUB_RATIO  (SUB_RATIO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .oneshot   (oneshot),
    .div_in    (div_in),
    .tick      (tick),
    .tick_slow (tick_slow),
    .busy      (busy),
    .done      (done)
`ifdef PULSE_TIMEBASE_TICK_COUNT_EN
    ,
    .tick_count(tick_count)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: a run is described by its start edge, period and tick tally.
  bit          m_run   = 1'b0;
  int          m_start = 0;
  int          m_per   = 1;
  bit          m_one   = 1'b0;
  int unsigned m_ticks = 0;
  logic        e_tick = 1'b0, e_slow = 1'b0, e_busy = 1'b0, e_done = 1'b0;

  int obs_ticks = 0, obs_slow = 0, obs_done = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  task automatic model_edge();
    if (rst) begin
      m_run = 1'b0; m_ticks = 0;
      e_tick = 1'b0; e_slow = 1'b0; e_busy = 1'b0; e_done = 1'b0;
    end else if (stop) begin
      m_run = 1'b0;
      e_tick = 1'b0; e_slow = 1'b0; e_busy = 1'b0; e_done = 1'b0;
    end else if (start) begin
      m_run = 1'b1; m_start = cyc; m_one = oneshot; m_ticks = 0;
      m_per = (div_in == '0) ? DEFAULT_DIV : int'(div_in);
      e_tick = 1'b0; e_slow = 1'b0; e_busy = 1'b1; e_done = 1'b0;
    end else if (m_run && ((cyc - m_start) % m_per == 0)) begin
      m_ticks++;
      e_tick = 1'b1;
      e_slow = (m_ticks % SUB_RATIO == 0);
      e_done = m_one;
      if (m_one) m_run = 1'b0;
      e_busy = m_run;
    end else begin
      e_tick = 1'b0; e_slow = 1'b0; e_done = 1'b0; e_busy = m_run;
    end
  endtask

  // One clock: model the edge with the inputs just sampled, then compare 1 ns later.
  task automatic step();
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    check("tick", 32'(tick), 32'(e_tick));
    check("tick_slow", 32'(tick_slow), 32'(e_slow));
    check("busy", 32'(busy), 32'(e_busy));
    check("done", 32'(done), 32'(e_done));
`ifdef PULSE_TIMEBASE_TICK_COUNT_EN
    check("tick_count", tick_count, m_ticks);
`endif
    if (tick === 1'b1) obs_ticks++;
    if (tick_slow === 1'b1) obs_slow++;
    if (done === 1'b1) obs_done++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clear_obs();
    obs_ticks = 0; obs_slow = 0; obs_done = 0;
  endtask

  task automatic pulse_start(input logic [DIV_WIDTH-1:0] d, input logic one);
    start = 1'b1; div_in = d; oneshot = one;
    step();
    start = 1'b0; oneshot = 1'b0;
  endtask

  initial begin
    // Reset held three cycles, then idle with no start.
    run(3);
    rst = 1'b0;
    clear_obs();
    run(10);
    check("idle ticks", obs_ticks, 0);

    // Continuous run, period 10: ticks every 10 cycles, slow tick on ticks 4, 8, 12.
    pulse_start(16'd10, 1'b0);
    clear_obs();
    run(130);
    check("p10 ticks", obs_ticks, 13);
    check("p10 slow", obs_slow, 3);

    // div_in = 0 selects the default period.
    stop = 1'b1; step(); stop = 1'b0;
    pulse_start(16'd0, 1'b0);
    clear_obs();
    run(2 * DEFAULT_DIV + DEFAULT_DIV / 2 - 10);
    check("default ticks", obs_ticks, 2);

    // One-shot, period 5: exactly one tick and one done.
    stop = 1'b1; step(); stop = 1'b0;
    pulse_start(16'd5, 1'b1);
    clear_obs();
    run(50);
    check("oneshot ticks", obs_ticks, 1);
    check("oneshot done", obs_done, 1);

    // Stop on the edge the second tick is due: it must be suppressed.
    pulse_start(16'd8, 1'b0);
    clear_obs();
    run(15);
    stop = 1'b1; step(); stop = 1'b0;
    check("stop suppress", obs_ticks, 1);
    run(3);
    // start and stop together: stop wins.
    start = 1'b1; stop = 1'b1; div_in = 16'd2; step();
    start = 1'b0; stop = 1'b0;
    clear_obs();
    run(20);
    check("stop wins", obs_ticks, 0);

    // start held high keeps restarting and never ticks.
    start = 1'b1; div_in = 16'd1;
    clear_obs();
    run(12);
    start = 1'b0;
    check("held start", obs_ticks, 0);
    run(3);

    // Restart mid-period (prescaler = 5) with a shorter period; slow counter restarts too.
    stop = 1'b1; step(); stop = 1'b0;
    pulse_start(16'd8, 1'b0);
    run(21);
    pulse_start(16'd3, 1'b0);
    clear_obs();
    run(12);
    check("restart ticks", obs_ticks, 4);
    check("restart slow", obs_slow, 1);

    // Random traffic: starts, stops, one-shots, occasional reset.
    for (int i = 0; i < 4000; i++) begin
      rst     = ($urandom_range(0, 799) == 0);
      stop    = ($urandom_range(0, 119) == 0);
      start   = ($urandom_range(0, 29) == 0);
      oneshot = 1'($urandom_range(0, 1));
      div_in  = DIV_WIDTH'($urandom_range(0, 12));
      step();
    end
    rst = 1'b0; stop = 1'b0; start = 1'b0;
    run(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
